// File: rtl/uart_rx_sampler_if.sv
// Receive-side signal bundle for uart_rx_sampler: serial pin in, byte write strobe and status out.
// master = the sampler, slave = the pin driver / byte consumer.
interface uart_rx_sampler_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  rx;
    logic                  valid;
    logic [DATA_WIDTH-1:0] result;
    logic                  frame_err;
    logic                  parity_err;
    logic                  busy;
    logic [2:0]            state_dbg;

    modport master (
        input  rx,
        output valid, result, frame_err, parity_err, busy, state_dbg
    );

    modport slave (
        output rx,
        input  valid, result, frame_err, parity_err, busy, state_dbg
    );
endinterface

// File: rtl/uart_rx_sampler.sv
// 8N1 UART receive sampler: synchronizes rx, samples mid-bit, emits one-cycle valid per good byte.
// Define UART_RX_PARITY_EN to receive 8E1 frames and report parity mismatches on parity_err.
module uart_rx_sampler #(
    parameter int CLKS_PER_BIT = 434,
    parameter int DATA_WIDTH   = 8,
    parameter int SYNC_STAGES  = 2
) (
    input logic              clk,
    input logic              rst,
    uart_rx_sampler_if.master bus
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int IW = $clog2(DATA_WIDTH + 1);
    localparam logic [CW-1:0] TERM = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [IW-1:0] LAST = IW'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        STOP   = 3'd3,
`ifdef UART_RX_PARITY_EN
        PARITY = 3'd5,
`endif
        BREAK  = 3'd4
    } state_t;

    state_t                  state_q, state_d;
    logic [SYNC_STAGES-1:0]  sync_q;
    logic [SYNC_STAGES-1:0]  fill_q;
    logic                    rx_s;
    logic                    rx_prev_q;
    logic [CW-1:0]           baud_cnt;
    logic [IW-1:0]           bit_idx;
    logic [DATA_WIDTH-1:0]   shift_q;
    logic [DATA_WIDTH-1:0]   result_q;
    logic                    valid_q, frame_err_q, parity_err_q;
    logic                    tick, cnt_clr, shift_en, deliver, ferr_set;
`ifdef UART_RX_PARITY_EN
    logic                    par_cap;
    logic                    par_bit_q;
`endif

    assign rx_s = sync_q[SYNC_STAGES-1];
    assign tick = (baud_cnt == TERM);

    // rx_prev only goes high once a genuine pin value has crossed the synchronizer,
    // so a line still low after reset never looks like a start edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q    <= '1;
            fill_q    <= '0;
            rx_prev_q <= 1'b0;
        end else begin
            sync_q    <= {sync_q[SYNC_STAGES-2:0], bus.rx};
            fill_q    <= {fill_q[SYNC_STAGES-2:0], 1'b1};
            rx_prev_q <= fill_q[SYNC_STAGES-1] & rx_s;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        cnt_clr  = 1'b0;
        shift_en = 1'b0;
        deliver  = 1'b0;
        ferr_set = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_cap  = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                cnt_clr = 1'b1;
                if (rx_prev_q && !rx_s) state_d = START;
            end
            START: begin
                if (baud_cnt == HALF) begin
                    cnt_clr = 1'b1;
                    state_d = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (tick) begin
                    shift_en = 1'b1;
`ifdef UART_RX_PARITY_EN
                    if (bit_idx == LAST) state_d = PARITY;
`else
                    if (bit_idx == LAST) state_d = STOP;
`endif
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (tick) begin
                    par_cap = 1'b1;
                    state_d = STOP;
                end
            end
`endif
            STOP: begin
                if (tick) begin
                    if (rx_s) begin
                        deliver = 1'b1;
                        state_d = IDLE;
                    end else begin
                        ferr_set = 1'b1;
                        state_d  = BREAK;
                    end
                end
            end
            BREAK: begin
                cnt_clr = 1'b1;
                if (rx_s) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            baud_cnt     <= '0;
            bit_idx      <= '0;
            shift_q      <= '0;
            result_q     <= '0;
            valid_q      <= 1'b0;
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bit_q    <= 1'b0;
`endif
        end else begin
            baud_cnt    <= (cnt_clr || tick) ? '0 : baud_cnt + 1'b1;
            bit_idx     <= (state_q != DATA) ? '0 : bit_idx + IW'(shift_en);
            if (shift_en) shift_q <= {rx_s, shift_q[DATA_WIDTH-1:1]};
            if (deliver)  result_q <= shift_q;
            valid_q     <= deliver;
            frame_err_q <= ferr_set;
`ifdef UART_RX_PARITY_EN
            if (par_cap) par_bit_q <= rx_s;
            parity_err_q <= deliver & ((^shift_q) ^ par_bit_q);
`else
            parity_err_q <= 1'b0;
`endif
        end
    end

    assign bus.valid      = valid_q;
    assign bus.result     = result_q;
    assign bus.frame_err  = frame_err_q;
    assign bus.parity_err = parity_err_q;
    assign bus.busy       = (state_q != IDLE);
    assign bus.state_dbg  = state_q;
endmodule
